// File: rtl/xmem_bram_pkg.sv
// Shared types and helpers for the xmem BRAM responder.
//   rsp_slot_t   : one in-flight response slot {valid, we, err}
//   dec_t        : result of decoding a mem_if byte address
//   addr_decode  : byte address -> {err, BRAM word index}
//   sat_inc32    : 32-bit saturating increment
package xmem_bram_pkg;

    localparam int BE_WIDTH = 32 / 8;  // byte enables for the default 32-bit bus

    typedef struct packed {
        logic valid;
        logic we;
        logic err;
    } rsp_slot_t;

    typedef struct packed {
        logic        err;
        logic [63:0] word;
    } dec_t;

    // Widened to 64 bits so one helper serves any ADDR_WIDTH up to 64.
    function automatic dec_t addr_decode(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input int unsigned off_bits,
                                         input int unsigned word_bits);
        dec_t        d;
        logic [63:0] off;
        logic [63:0] mask;
        logic [63:0] limit;
        off    = addr - base;
        mask   = (64'd1 << off_bits) - 64'd1;
        limit  = 64'd1 << word_bits;
        d.word = off >> off_bits;
        d.err  = (addr < base) || ((off & mask) != 64'd0) || (d.word >= limit);
        return d;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/xmem_bram_responder_if.sv
// mem_if req/gnt/rsp bundle between the mcore memory master and a responder.
//   master : drives req/addr/we/wdata/be, receives gnt and the response
//   slave  : the responder side
interface xmem_bram_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    mem_req;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic                    mem_we;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH/8-1:0] mem_be;
    logic                    mem_gnt;
    logic                    mem_rsp_valid;
    logic [DATA_WIDTH-1:0]   mem_rsp_rdata;
    logic                    mem_rsp_error;

    modport master (
        output mem_req, mem_addr, mem_we, mem_wdata, mem_be,
        input  mem_gnt, mem_rsp_valid, mem_rsp_rdata, mem_rsp_error
    );

    modport slave (
        input  mem_req, mem_addr, mem_we, mem_wdata, mem_be,
        output mem_gnt, mem_rsp_valid, mem_rsp_rdata, mem_rsp_error
    );
endinterface

// File: rtl/xmem_rsp_pipe.sv
// Fixed-depth shift register of response slots. A slot entering in cycle T
// appears on slot_out in cycle T+DEPTH.
//   clk, rst  : clock, synchronous active-high reset (clears all slots)
//   slot_in   : slot captured every cycle
//   slot_out  : oldest slot
module xmem_rsp_pipe
    import xmem_bram_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  rsp_slot_t slot_in,
    output rsp_slot_t slot_out
);

    rsp_slot_t [DEPTH-1:0] slot_q;
    rsp_slot_t [DEPTH-1:0] slot_d;

    always_comb begin
        slot_d    = slot_q;
        slot_d[0] = slot_in;
        for (int i = 1; i < DEPTH; i++) begin
            slot_d[i] = slot_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_out = slot_q[DEPTH-1];

endmodule

// File: rtl/xmem_bram_responder.sv
// Target side of mem_if mapped onto a single BRAM port. Every request is
// granted the cycle it is presented; each grant produces exactly one response
// BRAM_READ_LATENCY cycles later, reads and writes alike, so responses stay in
// grant order. Out-of-window or misaligned addresses never touch the BRAM and
// answer with error=1, rdata=0.
//   clka, rsta        : clock, synchronous active-high reset
//   mem               : mem_if slave (req/gnt/rsp)
//   bram_*            : BRAM port (byte write enables, word address)
//   cnt_clr           : synchronous counter clear, wins over increment
//   cnt_rd/wr/err     : saturating counts of granted reads/writes/errors
module xmem_bram_responder
    import xmem_bram_pkg::*;
#(
    parameter int                    DATA_WIDTH        = 32,
    parameter int                    ADDR_WIDTH        = 32,
    parameter int                    BRAM_ADDR_WIDTH   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR         = '0,
    parameter int                    BRAM_READ_LATENCY = 2
) (
    input  logic                       clka,
    input  logic                       rsta,
    xmem_bram_responder_if.slave       mem,
    output logic                       bram_en,
    output logic [DATA_WIDTH/8-1:0]    bram_we,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0]      bram_din,
    input  logic [DATA_WIDTH-1:0]      bram_dout,
    input  logic                       cnt_clr,
    output logic [31:0]                cnt_rd,
    output logic [31:0]                cnt_wr,
    output logic [31:0]                cnt_err
);

    localparam int          BE_W     = DATA_WIDTH / 8;
    localparam int unsigned OFF_BITS = $clog2(BE_W);

    logic      gnt;
    dec_t      dec;
    rsp_slot_t slot_in;
    rsp_slot_t slot_out;
    logic      rsp_valid;
    logic      unused_word_hi;

    always_comb begin
        gnt = mem.mem_req & ~rsta;
        dec = addr_decode(64'(mem.mem_addr), 64'(BASE_ADDR), OFF_BITS,
                          BRAM_ADDR_WIDTH);
    end

    assign unused_word_hi = ^dec.word[63:BRAM_ADDR_WIDTH];

    assign mem.mem_gnt = gnt;
    assign bram_en     = gnt & ~dec.err;
    assign bram_we     = (bram_en && mem.mem_we) ? mem.mem_be : '0;
    assign bram_addr   = dec.word[BRAM_ADDR_WIDTH-1:0];
    assign bram_din    = mem.mem_wdata;

    always_comb begin
        slot_in       = '0;
        slot_in.valid = gnt;
        slot_in.we    = mem.mem_we;
        slot_in.err   = dec.err;
    end

    xmem_rsp_pipe #(
        .DEPTH (BRAM_READ_LATENCY)
    ) u_rsp_pipe (
        .clk      (clka),
        .rst      (rsta),
        .slot_in  (slot_in),
        .slot_out (slot_out)
    );

    // Slots still visible in the first reset cycle belong to requests granted
    // before reset and must not produce a response.
    assign rsp_valid         = slot_out.valid & ~rsta;
    assign mem.mem_rsp_valid = rsp_valid;
    assign mem.mem_rsp_error = rsp_valid & slot_out.err;
    assign mem.mem_rsp_rdata = (rsp_valid && !slot_out.we && !slot_out.err) ? bram_dout : '0;

    logic [31:0] cnt_rd_q, cnt_rd_d;
    logic [31:0] cnt_wr_q, cnt_wr_d;
    logic [31:0] cnt_err_q, cnt_err_d;

    always_comb begin
        cnt_rd_d  = cnt_rd_q;
        cnt_wr_d  = cnt_wr_q;
        cnt_err_d = cnt_err_q;
        if (cnt_clr) begin
            cnt_rd_d  = '0;
            cnt_wr_d  = '0;
            cnt_err_d = '0;
        end else if (gnt) begin
            if (mem.mem_we) cnt_wr_d = sat_inc32(cnt_wr_q);
            else            cnt_rd_d = sat_inc32(cnt_rd_q);
            if (dec.err)    cnt_err_d = sat_inc32(cnt_err_q);
        end
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            cnt_rd_q  <= '0;
            cnt_wr_q  <= '0;
            cnt_err_q <= '0;
        end else begin
            cnt_rd_q  <= cnt_rd_d;
            cnt_wr_q  <= cnt_wr_d;
            cnt_err_q <= cnt_err_d;
        end
    end

    assign cnt_rd  = cnt_rd_q;
    assign cnt_wr  = cnt_wr_q;
    assign cnt_err = cnt_err_q;

endmodule
